// File: rtl/bounce_gen.sv
// Switch-chatter generator: turns a clean level into a bouncing button waveform
// driven by a 16-bit Fibonacci LFSR, settling after a fixed window per change.
module bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clean_in,
  output logic       btn_out,
  output logic       busy,
  output logic [7:0] burst_cnt
);

  localparam int unsigned CNT_W = $clog2(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_BOUNCE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              btn_out_q, btn_out_d;
  logic              busy_q, busy_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              level_q, level_d;
  logic              target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              lfsr_fb_c;

  // Taps 16,14,13,11 in right-shifting form land on bits 0,2,3,5.
  assign lfsr_fb_c = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clean_in != level_q) begin
            state_d = S_BOUNCE;
          end
        end
        S_BOUNCE: begin
          if ((clean_in == target_q) && (cnt_q == '0)) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; a retarget outranks window completion
  always_comb begin
    btn_out_d   = btn_out_q;
    busy_d      = busy_q;
    burst_cnt_d = burst_cnt_q;
    level_d     = level_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    lfsr_d      = {lfsr_fb_c, lfsr_q[15:1]};
    if (!en) begin
      btn_out_d = clean_in;
      level_d   = clean_in;
      target_d  = clean_in;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clean_in != level_q) begin
            target_d  = clean_in;
            cnt_d     = CNT_LOAD;
            btn_out_d = clean_in;
            busy_d    = 1'b1;
          end else begin
            btn_out_d = level_q;
          end
        end
        S_BOUNCE: begin
          if (clean_in != target_q) begin
            target_d  = clean_in;
            cnt_d     = CNT_LOAD;
            btn_out_d = clean_in;
          end else if (cnt_q == '0) begin
            btn_out_d   = target_q;
            level_d     = target_q;
            busy_d      = 1'b0;
            burst_cnt_d = burst_cnt_q + 8'd1;
          end else begin
            btn_out_d = lfsr_q[0];
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      burst_cnt_q <= 8'd0;
      level_q     <= 1'b0;
      target_q    <= 1'b0;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      btn_out_q   <= btn_out_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
      level_q     <= level_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign btn_out   = btn_out_q;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: window-end timeline model checked every cycle, plus
// hand-derived literal expectations for latency, chatter bits and counters.
module tb_bounce_gen;

  localparam int unsigned BC   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clean_in;
  logic       btn_out;
  logic       busy;
  logic [7:0] burst_cnt;

  int checks = 0;
  int errors = 0;

  bounce_gen #(.BOUNCE_CYCLES(BC), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .en(en), .clean_in(clean_in),
    .btn_out(btn_out), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  // Model: a window is described by its target and the edge number it ends on.
  logic        m_out, m_busy, m_level, m_tgt, m_active, chat;
  logic [7:0]  m_bursts;
  logic [15:0] m_lfsr;
  int          m_edge, m_end;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {^(v & 16'h002D), v[15:1]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = 1'b0; m_busy = 1'b0; m_level = 1'b0; m_tgt = 1'b0;
      m_active = 1'b0; m_bursts = 8'd0; m_lfsr = SEED; m_edge = 0; m_end = 0;
    end else begin
      chat   = m_lfsr[0];
      m_lfsr = lfsr_step(m_lfsr);
      m_edge = m_edge + 1;
      if (!en) begin
        m_out = clean_in; m_level = clean_in; m_tgt = clean_in; m_active = 1'b0;
      end else if (m_active) begin
        if (clean_in != m_tgt) begin
          m_tgt = clean_in; m_end = m_edge + BC; m_out = clean_in;
        end else if (m_edge == m_end) begin
          m_out = m_tgt; m_level = m_tgt; m_active = 1'b0; m_bursts = m_bursts + 8'd1;
        end else begin
          m_out = chat;
        end
      end else if (clean_in != m_level) begin
        m_active = 1'b1; m_tgt = clean_in; m_end = m_edge + BC; m_out = clean_in;
      end else begin
        m_out = m_level;
      end
      m_busy = m_active;
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if (btn_out !== m_out || busy !== m_busy || burst_cnt !== m_bursts) begin
      errors = errors + 1;
      $display("FAIL model t=%0t btn %b want %b busy %b want %b cnt %0d want %0d",
               $time, btn_out, m_out, busy, m_busy, burst_cnt, m_bursts);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Seed bits 6..14 and 1..9 of 16'hACE1, read LSB-first.
  logic [0:8] pat_run  = 9'b110011010;
  logic [0:8] pat_seed = 9'b000011100;
  int         busy_n;
  logic [7:0] base;

  initial begin
    rst = 1'b0; en = 1'b1; clean_in = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(5);
    chk("reset_btn", 8'(btn_out), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_cnt", burst_cnt, 8'd0);

    // First burst: change sampled at edge 6
    clean_in = 1'b1;
    cyc(1);
    chk("lead_edge", 8'(btn_out), 8'd1);
    busy_n = int'(busy);
    for (int k = 0; k < 9; k++) begin
      cyc(1);
      chk("chatter", 8'(btn_out), 8'(pat_run[k]));
      busy_n += int'(busy);
    end
    cyc(1);
    busy_n += int'(busy);
    chk("settle_btn", 8'(btn_out), 8'd1);
    chk("busy_len", 8'(busy_n), 8'(BC));
    chk("burst1", burst_cnt, 8'd1);
    cyc(3);
    chk("stable_btn", 8'(btn_out), 8'd1);

    // Return to 0, then retarget 0->1->0 four edges apart
    clean_in = 1'b0;
    cyc(12);
    base = burst_cnt;
    clean_in = 1'b1;
    cyc(4);
    clean_in = 1'b0;
    cyc(10);
    chk("retgt_busy", 8'(busy), 8'd1);
    cyc(1);
    chk("retgt_btn", 8'(btn_out), 8'd0);
    chk("retgt_idle", 8'(busy), 8'd0);
    chk("retgt_cnt", burst_cnt, base + 8'd1);

    // en=0 mid-window
    base = burst_cnt;
    clean_in = 1'b1;
    cyc(3);
    en = 1'b0;
    cyc(1);
    chk("dis_btn", 8'(btn_out), 8'd1);
    chk("dis_busy", 8'(busy), 8'd0);
    clean_in = 1'b0; cyc(1);
    chk("pass_0", 8'(btn_out), 8'd0);
    clean_in = 1'b1; cyc(1);
    chk("pass_1", 8'(btn_out), 8'd1);
    en = 1'b1;
    cyc(4);
    chk("reen_busy", 8'(busy), 8'd0);
    chk("reen_cnt", burst_cnt, base);

    // Asynchronous reset mid-window, then burst restarted from the seed
    clean_in = 1'b0;
    cyc(3);
    #2 rst = 1'b0;
    #1;
    chk("arst_btn", 8'(btn_out), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_cnt", burst_cnt, 8'd0);
    clean_in = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("rst_lead", 8'(btn_out), 8'd1);
    for (int k = 0; k < 9; k++) begin
      cyc(1);
      chk("seed_chat", 8'(btn_out), 8'(pat_seed[k]));
    end
    cyc(1);
    chk("rst_settle", 8'(btn_out), 8'd1);
    chk("rst_burst", burst_cnt, 8'd1);

    // Wrap: 255 more completed windows bring the count to 0
    for (int i = 0; i < 255; i++) begin
      clean_in = ~clean_in;
      cyc(12);
    end
    chk("wrap0", burst_cnt, 8'd0);
    clean_in = ~clean_in;
    cyc(12);
    chk("wrap1", burst_cnt, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
